// File: rtl/nova_io_pio_master_if.sv
// Signal bundle between the CPU execute stage, the PIO sequencer and the shared
// PIO device bus. The master modport is the sequencer's view of the bundle.
interface nova_io_pio_master_if;
  logic        io_start;
  logic [2:0]  io_op;
  logic [1:0]  io_ctl;
  logic [5:0]  io_dev;
  logic [15:0] io_acc;
  logic        io_busy;
  logic        io_done;
  logic [15:0] io_data;
  logic        io_skip;
  logic        bs_stb;
  logic        bs_we;
  logic [7:0]  bs_adr;
  logic [15:0] bs_din;
  logic [15:0] bs_dout;

  modport master (
    input  io_start, io_op, io_ctl, io_dev, io_acc, bs_dout,
    output io_busy, io_done, io_data, io_skip, bs_stb, bs_we, bs_adr, bs_din
  );

  modport slave (
    output io_start, io_op, io_ctl, io_dev, io_acc, bs_dout,
    input  io_busy, io_done, io_data, io_skip, bs_stb, bs_we, bs_adr, bs_din
  );
endinterface

// File: rtl/nova_io_pio_master.sv
// Nova I/O instruction sequencer: turns one NIO/DIx/DOx/SKP request into PIO
// bus strobes and returns the DIx read data or the SKP skip decision.
module nova_io_pio_master #(
  parameter int unsigned RD_LAT = 1
) (
  input logic                  pclk,
  input logic                  bs_rst_n,
  nova_io_pio_master_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_WAIT = 3'd2,
    ST_CTRL = 3'd3,
    ST_STAT = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  typedef struct packed {
    logic        stb;
    logic        we;
    logic [7:0]  adr;
    logic [15:0] din;
  } bus_acc_t;

  localparam logic [2:0] OP_NIO    = 3'd0;
  localparam logic [2:0] OP_SKP    = 3'd7;
  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 32'd1);
  localparam bus_acc_t   ACC_IDLE  = {1'b0, 1'b0, 8'h00, 16'h0000};

  function automatic logic [1:0] data_reg(input logic [2:0] op);
    case (op)
      3'd1, 3'd2: data_reg = 2'b01;
      3'd3, 3'd4: data_reg = 2'b10;
      3'd5, 3'd6: data_reg = 2'b11;
      default:    data_reg = 2'b00;
    endcase
  endfunction

  // Control write carries the S/C/P code in the low two data bits.
  function automatic bus_acc_t ctrl_acc(input logic [5:0] dev, input logic [1:0] ctl);
    ctrl_acc = {1'b1, 1'b1, dev, 2'b00, 14'h0000, ctl};
  endfunction

  // Status word: bit 0 busy, bit 1 done.
  function automatic logic skip_eval(input logic [1:0] ctl, input logic [1:0] status);
    case (ctl)
      2'b00:   skip_eval = status[0];
      2'b01:   skip_eval = ~status[0];
      2'b10:   skip_eval = status[1];
      2'b11:   skip_eval = ~status[1];
      default: skip_eval = 1'b0;
    endcase
  endfunction

  state_t      state_r;
  logic [2:0]  op_r;
  logic [1:0]  ctl_r;
  logic [5:0]  dev_r;
  logic [1:0]  wait_cnt_r;
  bus_acc_t    acc_r;
  logic        busy_r;
  logic        done_r;
  logic [15:0] data_r;
  logic        skip_r;

  // Instruction sequencer; every output is registered alongside the state.
  always_ff @(posedge pclk or negedge bs_rst_n) begin
    if (!bs_rst_n) begin
      state_r    <= ST_IDLE;
      op_r       <= 3'd0;
      ctl_r      <= 2'd0;
      dev_r      <= 6'd0;
      wait_cnt_r <= 2'd0;
      acc_r      <= ACC_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      data_r     <= 16'h0000;
      skip_r     <= 1'b0;
    end else begin
      acc_r  <= ACC_IDLE;
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.io_start && !busy_r) begin
            busy_r <= 1'b1;
            op_r   <= bus.io_op;
            ctl_r  <= bus.io_ctl;
            dev_r  <= bus.io_dev;
            skip_r <= 1'b0;
            case (bus.io_op)
              OP_NIO: begin
                if (bus.io_ctl != 2'b00) begin
                  state_r <= ST_CTRL;
                  acc_r   <= ctrl_acc(bus.io_dev, bus.io_ctl);
                end else begin
                  state_r <= ST_DONE;
                  done_r  <= 1'b1;
                end
              end
              OP_SKP: begin
                state_r <= ST_STAT;
                acc_r   <= {1'b1, 1'b0, bus.io_dev, 2'b00, 16'h0000};
              end
              default: begin
                state_r <= ST_DATA;
                acc_r   <= {1'b1, ~bus.io_op[0], bus.io_dev, data_reg(bus.io_op),
                            bus.io_op[0] ? 16'h0000 : bus.io_acc};
              end
            endcase
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (op_r[0]) begin
            state_r    <= ST_WAIT;
            wait_cnt_r <= 2'd0;
          end else if (ctl_r != 2'b00) begin
            state_r <= ST_CTRL;
            acc_r   <= ctrl_acc(dev_r, ctl_r);
          end else begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        ST_STAT: begin
          state_r    <= ST_WAIT;
          wait_cnt_r <= 2'd0;
        end
        ST_WAIT: begin
          if (wait_cnt_r != WAIT_LAST) begin
            wait_cnt_r <= (wait_cnt_r == 2'd3) ? 2'd3 : wait_cnt_r + 2'd1;
          end else if (op_r == OP_SKP) begin
            skip_r  <= skip_eval(ctl_r, bus.bs_dout[1:0]);
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            data_r <= bus.bs_dout;
            if (ctl_r != 2'b00) begin
              state_r <= ST_CTRL;
              acc_r   <= ctrl_acc(dev_r, ctl_r);
            end else begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end
          end
        end
        ST_CTRL: begin
          state_r <= ST_DONE;
          done_r  <= 1'b1;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.io_busy = busy_r;
  assign bus.io_done = done_r;
  assign bus.io_data = data_r;
  assign bus.io_skip = skip_r;
  assign bus.bs_stb  = acc_r.stb;
  assign bus.bs_we   = acc_r.we;
  assign bus.bs_adr  = acc_r.adr;
  assign bus.bs_din  = acc_r.din;

endmodule

// File: tb/tb_nova_io_pio_master.sv
// Scoreboard bench: two sequencers (read latency 1 and 3), each with a small
// dummy PIO device; expected bus accesses and completions are queued at issue.
module tb_nova_io_pio_master;

  typedef struct {
    int d; logic [2:0] op; logic [1:0] ctl; logic [5:0] dev; logic [15:0] acc;
    int lat; logic [15:0] data; bit cs; bit sk;
    int l0; bit w0; logic [7:0] ad0; logic [15:0] dn0;
    int l1; bit w1; logic [7:0] ad1; logic [15:0] dn1;
  } vec_t;

  typedef struct { int d; int cyc; logic [15:0] data; bit cs; bit sk; } done_exp_t;
  typedef struct { int d; int cyc; bit we; logic [7:0] adr; logic [15:0] din; } bus_exp_t;

  localparam logic [5:0] DEV1 = 6'o10;

  logic pclk = 1'b0;
  logic bs_rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  done_exp_t done_q[$];
  bus_exp_t  bus_q[$];
  vec_t      tbl[21];

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  nova_io_pio_master_if bus1();
  nova_io_pio_master_if bus3();

  nova_io_pio_master #(.RD_LAT(1)) u_dut1 (.pclk(pclk), .bs_rst_n(bs_rst_n), .bus(bus1));
  nova_io_pio_master #(.RD_LAT(3)) u_dut3 (.pclk(pclk), .bs_rst_n(bs_rst_n), .bus(bus3));

  // Device at 0o10 on bus1: registers A/B/C plus busy/done flags, 1-cycle read.
  logic [15:0] d1_a = 16'h0000, d1_b = 16'hBEEF, d1_c = 16'h0000, d1_rd = 16'h0000;
  logic        d1_busy = 1'b0, d1_done = 1'b0;
  int          d1_cnt = 0;
  always @(posedge pclk) begin
    if (bus1.bs_stb && bus1.bs_adr[7:2] == DEV1) begin
      if (bus1.bs_we) begin
        case (bus1.bs_adr[1:0])
          2'b00: case (bus1.bs_din[1:0])
                   2'b01:   begin d1_busy <= 1'b1; d1_done <= 1'b0; end
                   2'b10:   begin d1_busy <= 1'b0; d1_done <= 1'b0; end
                   2'b11:   begin d1_busy <= 1'b0; d1_done <= 1'b1; end
                   default: ;
                 endcase
          2'b01:   d1_a <= bus1.bs_din;
          2'b10:   d1_b <= bus1.bs_din;
          default: d1_c <= bus1.bs_din;
        endcase
        d1_cnt <= 0;
      end else begin
        case (bus1.bs_adr[1:0])
          2'b00:   d1_rd <= {14'h0000, d1_done, d1_busy};
          2'b01:   d1_rd <= d1_a;
          2'b10:   d1_rd <= d1_b;
          default: d1_rd <= d1_c;
        endcase
        d1_cnt <= 1;
      end
    end else if (d1_cnt != 0) d1_cnt <= d1_cnt - 1;
  end
  assign bus1.bs_dout = (d1_cnt == 1) ? d1_rd : 16'hDEAD;

  // Read-only device on bus3 answering every code, data valid 3 cycles after the strobe.
  logic [15:0] d3_rd = 16'h0000;
  int          d3_cnt = 0;
  always @(posedge pclk) begin
    if (bus3.bs_stb && !bus3.bs_we) begin
      case (bus3.bs_adr[1:0])
        2'b00:   d3_rd <= 16'h0002;
        2'b01:   d3_rd <= 16'h0A0A;
        2'b10:   d3_rd <= 16'h0B0B;
        default: d3_rd <= 16'hC0DE;
      endcase
      d3_cnt <= 3;
    end else if (d3_cnt != 0) d3_cnt <= d3_cnt - 1;
  end
  assign bus3.bs_dout = (d3_cnt == 1) ? d3_rd : 16'hF00D;

  logic m_busy[2], m_done[2], m_skip[2], m_stb[2], m_we[2];
  logic [7:0]  m_adr[2];
  logic [15:0] m_din[2], m_data[2];
  assign m_busy[0] = bus1.io_busy; assign m_busy[1] = bus3.io_busy;
  assign m_done[0] = bus1.io_done; assign m_done[1] = bus3.io_done;
  assign m_skip[0] = bus1.io_skip; assign m_skip[1] = bus3.io_skip;
  assign m_stb[0]  = bus1.bs_stb;  assign m_stb[1]  = bus3.bs_stb;
  assign m_we[0]   = bus1.bs_we;   assign m_we[1]   = bus3.bs_we;
  assign m_adr[0]  = bus1.bs_adr;  assign m_adr[1]  = bus3.bs_adr;
  assign m_din[0]  = bus1.bs_din;  assign m_din[1]  = bus3.bs_din;
  assign m_data[0] = bus1.io_data; assign m_data[1] = bus3.io_data;

  // Monitor: pops expectations whenever a DUT strobes or completes; stale entries fail.
  always @(negedge pclk) begin
    done_exp_t de;
    bus_exp_t  be;
    if (!bs_rst_n) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (m_busy[d] || m_done[d] || m_skip[d] || m_stb[d] || m_we[d] ||
            m_adr[d] != 8'h00 || m_din[d] != 16'h0000 || m_data[d] != 16'h0000) begin
          errors++;
          $display("FAIL reset_state dut%0d: busy=%b done=%b skip=%b stb=%b we=%b adr=%h din=%h data=%h, required all 0",
                   d, m_busy[d], m_done[d], m_skip[d], m_stb[d], m_we[d], m_adr[d], m_din[d], m_data[d]);
        end
      end
    end else begin
      while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
        de = done_q.pop_front();
        checks++; errors++;
        $display("FAIL done_missing dut%0d: got no io_done, required at cycle %0d", de.d, de.cyc);
      end
      while (bus_q.size() > 0 && bus_q[0].cyc < cyc) begin
        be = bus_q.pop_front();
        checks++; errors++;
        $display("FAIL bus_missing dut%0d: got no strobe, required at cycle %0d adr=%h", be.d, be.cyc, be.adr);
      end
      for (int d = 0; d < 2; d++) begin
        if (m_done[d]) begin
          checks++;
          if (done_q.size() == 0 || done_q[0].d != d) begin
            errors++;
            $display("FAIL done_unexpected dut%0d: got io_done at cycle %0d, required none", d, cyc);
          end else begin
            de = done_q.pop_front();
            if (de.cyc != cyc || de.data != m_data[d] || (de.cs && de.sk != m_skip[d])) begin
              errors++;
              $display("FAIL done dut%0d: got cyc=%0d data=%h skip=%b, required cyc=%0d data=%h skip=%b",
                       d, cyc, m_data[d], m_skip[d], de.cyc, de.data, de.cs ? de.sk : m_skip[d]);
            end
          end
        end
        if (m_stb[d]) begin
          checks++;
          if (bus_q.size() == 0 || bus_q[0].d != d) begin
            errors++;
            $display("FAIL bus_unexpected dut%0d: got we=%b adr=%h din=%h at cycle %0d, required no access",
                     d, m_we[d], m_adr[d], m_din[d], cyc);
          end else begin
            be = bus_q.pop_front();
            if (be.cyc != cyc || be.we != m_we[d] || be.adr != m_adr[d] || be.din != m_din[d]) begin
              errors++;
              $display("FAIL bus dut%0d: got cyc=%0d we=%b adr=%h din=%h, required cyc=%0d we=%b adr=%h din=%h",
                       d, cyc, m_we[d], m_adr[d], m_din[d], be.cyc, be.we, be.adr, be.din);
            end
          end
        end else begin
          checks++;
          if (m_we[d] || m_adr[d] != 8'h00 || m_din[d] != 16'h0000) begin
            errors++;
            $display("FAIL bus_idle dut%0d: got we=%b adr=%h din=%h, required 0", d, m_we[d], m_adr[d], m_din[d]);
          end
        end
      end
    end
  end

  function automatic vec_t mk(input int d, input logic [2:0] op, input logic [1:0] ctl,
                              input logic [5:0] dev, input logic [15:0] acc, input int lat,
                              input logic [15:0] data, input bit cs, input bit sk,
                              input int l0 = 0, input bit w0 = 1'b0, input logic [7:0] ad0 = 8'h00,
                              input logic [15:0] dn0 = 16'h0000, input int l1 = 0, input bit w1 = 1'b0,
                              input logic [7:0] ad1 = 8'h00, input logic [15:0] dn1 = 16'h0000);
    vec_t v;
    v.d = d; v.op = op; v.ctl = ctl; v.dev = dev; v.acc = acc; v.lat = lat;
    v.data = data; v.cs = cs; v.sk = sk;
    v.l0 = l0; v.w0 = w0; v.ad0 = ad0; v.dn0 = dn0;
    v.l1 = l1; v.w1 = w1; v.ad1 = ad1; v.dn1 = dn1;
    return v;
  endfunction

  task automatic drive(input int d, input logic st, input logic [2:0] op, input logic [1:0] ctl,
                       input logic [5:0] dev, input logic [15:0] acc);
    if (d == 0) begin
      bus1.io_start = st; bus1.io_op = op; bus1.io_ctl = ctl; bus1.io_dev = dev; bus1.io_acc = acc;
    end else begin
      bus3.io_start = st; bus3.io_op = op; bus3.io_ctl = ctl; bus3.io_dev = dev; bus3.io_acc = acc;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    done_exp_t de;
    bus_exp_t  be;
    for (int i = 0; i < 64; i++) begin
      if (!m_busy[v.d]) break;
      @(negedge pclk);
    end
    k = cyc;
    drive(v.d, 1'b1, v.op, v.ctl, v.dev, v.acc);
    de.d = v.d; de.cyc = k + v.lat; de.data = v.data; de.cs = v.cs; de.sk = v.sk;
    done_q.push_back(de);
    if (v.l0 != 0) begin
      be.d = v.d; be.cyc = k + v.l0; be.we = v.w0; be.adr = v.ad0; be.din = v.dn0;
      bus_q.push_back(be);
    end
    if (v.l1 != 0) begin
      be.d = v.d; be.cyc = k + v.l1; be.we = v.w1; be.adr = v.ad1; be.din = v.dn1;
      bus_q.push_back(be);
    end
    @(negedge pclk);
    drive(v.d, 1'b0, 3'd0, 2'd0, 6'd0, 16'h0000);
    for (int i = 0; i < 64; i++) begin
      if (!m_busy[v.d]) break;
      @(negedge pclk);
    end
  endtask

  initial begin
    int k;
    done_exp_t de;
    bus_exp_t  be;
    tbl[0]  = mk(0, 3'd2, 2'd0, DEV1, 16'h1234, 2, 16'h0000, 1'b0, 1'b0, 1, 1'b1, 8'h21, 16'h1234);
    tbl[1]  = mk(0, 3'd3, 2'd1, DEV1, 16'h0000, 4, 16'hBEEF, 1'b0, 1'b0, 1, 1'b0, 8'h22, 16'h0000,
                 3, 1'b1, 8'h20, 16'h0001);
    tbl[2]  = mk(0, 3'd0, 2'd1, DEV1, 16'h0000, 2, 16'hBEEF, 1'b0, 1'b0, 1, 1'b1, 8'h20, 16'h0001);
    tbl[3]  = mk(0, 3'd7, 2'd1, DEV1, 16'h0000, 3, 16'hBEEF, 1'b1, 1'b0, 1, 1'b0, 8'h20, 16'h0000);
    tbl[4]  = mk(0, 3'd7, 2'd0, DEV1, 16'h0000, 3, 16'hBEEF, 1'b1, 1'b1, 1, 1'b0, 8'h20, 16'h0000);
    tbl[5]  = mk(0, 3'd0, 2'd3, DEV1, 16'h0000, 2, 16'hBEEF, 1'b0, 1'b0, 1, 1'b1, 8'h20, 16'h0003);
    tbl[6]  = mk(0, 3'd7, 2'd2, DEV1, 16'h0000, 3, 16'hBEEF, 1'b1, 1'b1, 1, 1'b0, 8'h20, 16'h0000);
    tbl[7]  = mk(0, 3'd0, 2'd2, DEV1, 16'h0000, 2, 16'hBEEF, 1'b0, 1'b0, 1, 1'b1, 8'h20, 16'h0002);
    tbl[8]  = mk(0, 3'd7, 2'd3, DEV1, 16'h0000, 3, 16'hBEEF, 1'b1, 1'b1, 1, 1'b0, 8'h20, 16'h0000);
    tbl[9]  = mk(0, 3'd7, 2'd1, DEV1, 16'h0000, 3, 16'hBEEF, 1'b1, 1'b1, 1, 1'b0, 8'h20, 16'h0000);
    tbl[10] = mk(0, 3'd6, 2'd2, DEV1, 16'hA5A5, 3, 16'hBEEF, 1'b0, 1'b0, 1, 1'b1, 8'h23, 16'hA5A5,
                 2, 1'b1, 8'h20, 16'h0002);
    tbl[11] = mk(0, 3'd5, 2'd0, DEV1, 16'h0000, 3, 16'hA5A5, 1'b0, 1'b0, 1, 1'b0, 8'h23, 16'h0000);
    tbl[12] = mk(0, 3'd1, 2'd0, DEV1, 16'h0000, 3, 16'h1234, 1'b0, 1'b0, 1, 1'b0, 8'h21, 16'h0000);
    tbl[13] = mk(0, 3'd0, 2'd0, DEV1, 16'h0000, 1, 16'h1234, 1'b0, 1'b0);
    tbl[14] = mk(0, 3'd4, 2'd0, 6'o21, 16'h0F0F, 2, 16'h1234, 1'b0, 1'b0, 1, 1'b1, 8'h46, 16'h0F0F);
    tbl[15] = mk(1, 3'd5, 2'd0, 6'd5, 16'h0000, 5, 16'hC0DE, 1'b0, 1'b0, 1, 1'b0, 8'h17, 16'h0000);
    tbl[16] = mk(1, 3'd1, 2'd1, 6'd5, 16'h0000, 6, 16'h0A0A, 1'b0, 1'b0, 1, 1'b0, 8'h15, 16'h0000,
                 5, 1'b1, 8'h14, 16'h0001);
    tbl[17] = mk(1, 3'd7, 2'd2, 6'd5, 16'h0000, 5, 16'h0A0A, 1'b1, 1'b1, 1, 1'b0, 8'h14, 16'h0000);
    tbl[18] = mk(0, 3'd0, 2'd0, DEV1, 16'h0000, 1, 16'h0000, 1'b0, 1'b0);
    tbl[19] = mk(1, 3'd0, 2'd0, 6'd5, 16'h0000, 1, 16'h0000, 1'b0, 1'b0);
    tbl[20] = mk(0, 3'd3, 2'd0, DEV1, 16'h0000, 3, 16'hBEEF, 1'b0, 1'b0, 1, 1'b0, 8'h22, 16'h0000);

    bs_rst_n = 1'b0;
    drive(0, 1'b0, 3'd0, 2'd0, 6'd0, 16'h0000);
    drive(1, 1'b0, 3'd0, 2'd0, 6'd0, 16'h0000);
    repeat (3) @(negedge pclk);
    @(posedge pclk);
    #2 bs_rst_n = 1'b1;
    @(negedge pclk);

    for (int i = 0; i < 18; i++) run_vec(tbl[i]);

    // io_start held for 10 cycles: NIO/none is accepted on every other edge.
    k = cyc;
    drive(0, 1'b1, 3'd0, 2'd0, DEV1, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      de.d = 0; de.cyc = k + 1 + 2 * i; de.data = 16'h1234; de.cs = 1'b0; de.sk = 1'b0;
      done_q.push_back(de);
    end
    repeat (10) @(negedge pclk);
    drive(0, 1'b0, 3'd0, 2'd0, 6'd0, 16'h0000);
    repeat (2) @(negedge pclk);

    // Reset asserted in the WAIT cycle of a DIA: no completion may follow.
    k = cyc;
    drive(0, 1'b1, 3'd1, 2'd0, DEV1, 16'h0000);
    be.d = 0; be.cyc = k + 1; be.we = 1'b0; be.adr = 8'h21; be.din = 16'h0000;
    bus_q.push_back(be);
    @(negedge pclk);
    drive(0, 1'b0, 3'd0, 2'd0, 6'd0, 16'h0000);
    @(posedge pclk);
    #2 bs_rst_n = 1'b0;
    repeat (2) @(negedge pclk);
    @(posedge pclk);
    #2 bs_rst_n = 1'b1;
    repeat (3) @(negedge pclk);

    for (int i = 18; i < 21; i++) run_vec(tbl[i]);

    repeat (10) @(negedge pclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
